// File: rtl/tinyalu_pkg.sv
// -----------------------------------------------------------------------------
// tinyalu_pkg
// Shared types and constants for the tinyalu requester arbiter.
//   op_e     : tinyalu opcodes (3'b101..3'b111 are illegal and have no name)
//   state_e  : arbiter controller states
//   LAT_*    : accept-to-response latencies in clock cycles
//   op_is_legal / op_needs_alu : opcode classification helpers
// -----------------------------------------------------------------------------
package tinyalu_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_MUL = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP,
    ST_DRAIN
  } state_e;

  localparam int LAT_NOP    = 1;
  localparam int LAT_SINGLE = 3;
  localparam int LAT_MUL    = 6;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_MUL);
  endfunction

  // NOP and illegal opcodes are answered directly without touching the ALU.
  function automatic logic op_needs_alu(input logic [2:0] op);
    return op_is_legal(op) && (op != OP_NOP);
  endfunction

endpackage

// File: rtl/tinyalu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tinyalu_rr_arbiter
// Combinational round-robin grant: picks the lowest requester index at or
// above the pointer, wrapping around past N-1.
//   N      : number of requesters (2..8)
//   req    : in,  N bits, request vector
//   ptr    : in,  $clog2(N) bits, highest-priority index this cycle
//   grant  : out, N bits, one-hot grant (all zero when req is zero)
// -----------------------------------------------------------------------------
module tinyalu_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  localparam int PW = $clog2(N);
  localparam int SW = PW + 1;

  // Walk the candidates in priority order starting at ptr. The sum is kept one
  // bit wider so the wrap works for requester counts that are not a power of two.
  always_comb begin
    logic          found;
    logic [SW-1:0] sum;
    logic [PW-1:0] idx;
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(N)) begin
        sum = sum - SW'(N);
      end
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tinyalu_arbiter.sv
// -----------------------------------------------------------------------------
// tinyalu_arbiter
// Shares one tinyalu between NUM_REQ requesters. A granted request has its
// operands latched, the ALU start/done handshake is sequenced, and the result
// is returned to the owner as a one-cycle response pulse. After a multiply,
// MUL_DRAIN quiet cycles are inserted before the next issue.
//
// Optional build macro: TINYALU_ARB_TIMEOUT_EN
//   When defined, BUSY is aborted after TIMEOUT_CYCLES cycles without alu_done
//   and the owner receives rsp_err=1, rsp_result=0.
//
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   req_valid[NUM_REQ]    : per-requester request
//   req_ready[NUM_REQ]    : one-hot accept (combinational, IDLE only)
//   req_A/req_B[8*NUM_REQ]: operands, slice i belongs to requester i
//   req_op[3*NUM_REQ]     : opcodes
//   rsp_valid[NUM_REQ]    : one-hot response pulse
//   rsp_result[16]        : result, valid with rsp_valid
//   rsp_err               : error flag, valid with rsp_valid
//   alu_A/alu_B/alu_op    : ALU operands and opcode (hold last value)
//   alu_start             : ALU start, high throughout BUSY
//   alu_done, alu_result  : ALU completion and result
// -----------------------------------------------------------------------------
module tinyalu_arbiter
  import tinyalu_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int MUL_DRAIN      = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [8*NUM_REQ-1:0]   req_A,
  input  logic [8*NUM_REQ-1:0]   req_B,
  input  logic [3*NUM_REQ-1:0]   req_op,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [15:0]            rsp_result,
  output logic                   rsp_err,
  output logic [7:0]             alu_A,
  output logic [7:0]             alu_B,
  output logic [2:0]             alu_op,
  output logic                   alu_start,
  input  logic                   alu_done,
  input  logic [15:0]            alu_result
);

  localparam int PW = $clog2(NUM_REQ);

  state_e state, state_next;

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      owner;
  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      grant_idx;
  logic [7:0]         grant_a;
  logic [7:0]         grant_b;
  logic [2:0]         grant_op;
  logic               accept;
  logic               timeout_hit;

  logic [7:0]         a_q;
  logic [7:0]         b_q;
  logic [2:0]         op_q;
  logic [15:0]        result_q;
  logic               err_q;
  logic               drain_after_q;
  logic [7:0]         drain_cnt;

  tinyalu_rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Encode the one-hot grant and pick out the winner's operand slices.
  always_comb begin
    grant_idx = '0;
    grant_a   = '0;
    grant_b   = '0;
    grant_op  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = PW'(i);
        grant_a   = req_A[i*8 +: 8];
        grant_b   = req_B[i*8 +: 8];
        grant_op  = req_op[i*3 +: 3];
      end
    end
  end

  assign accept    = (state == ST_IDLE) && (|req_valid);
  // Gated with reset_n so the accept vector is quiet while reset is held.
  assign req_ready = ((state == ST_IDLE) && reset_n) ? grant : '0;

`ifdef TINYALU_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;

  // Counts BUSY cycles; restarts from zero every time BUSY is entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (state != ST_BUSY) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign timeout_hit = (state == ST_BUSY) && !alu_done &&
                       (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. DRAIN exits on the cycle the counter would reach zero,
  // so exactly MUL_DRAIN drain cycles are spent (at least one).
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = op_needs_alu(grant_op) ? ST_BUSY : ST_RESP;
        end
      end
      ST_BUSY: begin
        if (alu_done || timeout_hit) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        state_next = drain_after_q ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (drain_cnt <= 8'd1) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request latch, result capture, pointer and drain counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr        <= '0;
      owner         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      result_q      <= '0;
      err_q         <= 1'b0;
      drain_after_q <= 1'b0;
      drain_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q           <= grant_a;
            b_q           <= grant_b;
            op_q          <= grant_op;
            owner         <= grant_idx;
            rr_ptr        <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
            result_q      <= '0;
            err_q         <= !op_is_legal(grant_op);
            drain_after_q <= (grant_op == OP_MUL);
          end
        end
        ST_BUSY: begin
          if (alu_done) begin
            result_q <= alu_result;
          end else if (timeout_hit) begin
            err_q         <= 1'b1;
            drain_after_q <= 1'b1;
          end
        end
        ST_RESP: begin
          drain_cnt <= 8'(MUL_DRAIN);
        end
        ST_DRAIN: begin
          if (drain_cnt != 8'd0) begin
            drain_cnt <= drain_cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Response pulse decode for the owner of the operation in flight.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = (state == ST_RESP) && (owner == PW'(i));
    end
  end

  assign rsp_result = (state == ST_RESP) ? result_q : '0;
  assign rsp_err    = (state == ST_RESP) && err_q;

  assign alu_A     = a_q;
  assign alu_B     = b_q;
  assign alu_op    = op_q;
  assign alu_start = (state == ST_BUSY);

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tinyalu_arbiter
// Scoreboard bench for tinyalu_arbiter with a behavioural tinyalu model
// (single-cycle ops answer one cycle after start, MUL four cycles after).
// Define TINYALU_ARB_TIMEOUT_EN to also exercise the BUSY timeout.
// -----------------------------------------------------------------------------
module tb_tinyalu_arbiter;
  import tinyalu_pkg::*;

  localparam int NUM_REQ        = 4;
  localparam int MUL_DRAIN      = 2;
  localparam int TIMEOUT_CYCLES = 15;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [8*NUM_REQ-1:0] req_A;
  logic [8*NUM_REQ-1:0] req_B;
  logic [3*NUM_REQ-1:0] req_op;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [15:0]          rsp_result;
  logic                 rsp_err;
  logic [7:0]           alu_A;
  logic [7:0]           alu_B;
  logic [2:0]           alu_op;
  logic                 alu_start;
  logic                 alu_done;
  logic [15:0]          alu_result;

  always #5 clk = ~clk;

  tinyalu_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .MUL_DRAIN      (MUL_DRAIN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_A      (req_A),
    .req_B      (req_B),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result)
  );

  // Reference arithmetic of the tinyalu.
  function automatic logic [15:0] aluCompute(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b001:  return 16'(a) + 16'(b);
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      3'b100:  return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  // Behavioural ALU: done once start has been seen for the op's latency.
  logic [4:0] alu_cnt;
  bit         alu_stall = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) alu_cnt <= '0;
    else if (alu_start && !alu_done) alu_cnt <= alu_cnt + 5'd1;
    else alu_cnt <= '0;
  end

  assign alu_done   = alu_start && !alu_stall && (alu_cnt == ((alu_op == 3'b100) ? 5'd4 : 5'd1));
  assign alu_result = aluCompute(alu_op, alu_A, alu_B);

  typedef struct {
    int          owner;
    logic [15:0] result;
    logic        err;
    int          due;
  } exp_t;

  exp_t               sb[$];
  int                 grant_log[$];
  int                 acc_cyc_log[$];
  int                 checks = 0;
  int                 errors = 0;
  int                 cyc = 0;
  int                 start_count = 0;
  logic [NUM_REQ-1:0] accept_mask = '0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  function automatic int grantAt(input int i);
    if (i < grant_log.size()) return grant_log[i];
    return -1;
  endfunction

  function automatic int acceptAt(input int i);
    if (i < acc_cyc_log.size()) return acc_cyc_log[i];
    return -1000;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor on the falling edge: records accepts into the scoreboard and
  // checks every response against the oldest outstanding expectation.
  always @(negedge clk) begin
    int          g;
    exp_t        e;
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    g  = -1;
    op = '0;
    a  = '0;
    b  = '0;
    if (!reset_n) begin
      sb.delete();
      accept_mask = '0;
    end else begin
      accept_mask = req_ready;
      if (alu_start) start_count++;
      if (req_ready != '0) begin
        checkOutput("ready_onehot", $countones(req_ready), 1);
        for (int i = NUM_REQ - 1; i >= 0; i--) if (req_ready[i]) g = i;
        op      = req_op[g*3 +: 3];
        a       = req_A[g*8 +: 8];
        b       = req_B[g*8 +: 8];
        e.owner = g;
        e.err   = (op > 3'b100);
        e.result = e.err ? 16'h0000 : aluCompute(op, a, b);
        if (op == 3'b000 || op > 3'b100) e.due = cyc + LAT_NOP;
        else if (alu_stall) begin
          e.due    = cyc + TIMEOUT_CYCLES + 1;
          e.err    = 1'b1;
          e.result = 16'h0000;
        end
        else if (op == 3'b100) e.due = cyc + LAT_MUL;
        else e.due = cyc + LAT_SINGLE;
        sb.push_back(e);
        grant_log.push_back(g);
        acc_cyc_log.push_back(cyc);
      end
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("rsp_owner", 32'(rsp_valid), 32'd1 << e.owner);
          checkOutput("rsp_result", 32'(rsp_result), 32'(e.result));
          checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
          checkOutput("rsp_cycle", cyc, e.due);
        end
      end else begin
        checkOutput("rsp_idle_zero", {15'd0, rsp_err, rsp_result}, 32'd0);
        if (sb.size() != 0 && cyc > sb[0].due) begin
          e = sb.pop_front();
          checkOutput("rsp_missing", cyc, e.due);
        end
      end
    end
  end

  // Advance one cycle; drop req_valid for whoever was just accepted.
  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~accept_mask;
  endtask

  task automatic applyStimulus(input int idx, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_A[idx*8 +: 8] = a;
    req_B[idx*8 +: 8] = b;
    req_op[idx*3 +: 3] = op;
    req_valid[idx]     = 1'b1;
  endtask

  task automatic waitDrained(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || req_valid != '0) && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0 || req_valid != '0)
      checkOutput("wait_budget", sb.size() + $countones(req_valid), 0);
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int s0;
    logic [2:0] rop;
    reset_n   = 1'b0;
    req_valid = '0;
    req_A     = '0;
    req_B     = '0;
    req_op    = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_alu_start", 32'(alu_start), 32'd0);
    checkOutput("rst_alu_ops", {8'd0, alu_A, alu_B, 5'd0, alu_op}, 32'd0);
    checkOutput("rst_rsp_data", {15'd0, rsp_err, rsp_result}, 32'd0);
    reset_n = 1'b1;
    tick();

    $display("[TB] ADD with late operand change");
    base = grant_log.size();
    applyStimulus(0, 3'b001, 8'hFF, 8'h01);
    tick();
    req_A[7:0] = 8'h55;
    req_B[7:0] = 8'h77;
    waitDrained(50);
    checkOutput("add_grant", grantAt(base), 0);

    $display("[TB] MUL then drain");
    base = grant_log.size();
    applyStimulus(1, 3'b100, 8'hFF, 8'hFF);
    tick();
    applyStimulus(2, 3'b001, 8'h12, 8'h34);
    waitDrained(60);
    checkOutput("mul_grant", grantAt(base), 1);
    checkOutput("post_mul_grant", grantAt(base + 1), 2);
    checkOutput("mul_drain_gap", 32'(acceptAt(base + 1) - acceptAt(base) >= 7 + MUL_DRAIN), 32'd1);

    $display("[TB] round-robin order");
    base = grant_log.size();
    applyStimulus(3, 3'b000, 8'h00, 8'h00);
    waitDrained(30);
    checkOutput("rr_wrap_grant", grantAt(base), 3);
    base = grant_log.size();
    applyStimulus(0, 3'b001, 8'h21, 8'h43);
    applyStimulus(1, 3'b010, 8'hF0, 8'h3C);
    applyStimulus(2, 3'b011, 8'hA5, 8'h5A);
    waitDrained(60);
    checkOutput("rr_grant0", grantAt(base), 0);
    checkOutput("rr_grant1", grantAt(base + 1), 1);
    checkOutput("rr_grant2", grantAt(base + 2), 2);
    base = grant_log.size();
    applyStimulus(0, 3'b011, 8'h0F, 8'hFF);
    applyStimulus(3, 3'b001, 8'h80, 8'h80);
    waitDrained(60);
    checkOutput("rr_grant3_first", grantAt(base), 3);
    checkOutput("rr_grant0_second", grantAt(base + 1), 0);

    $display("[TB] NOP and illegal opcodes");
    s0 = start_count;
    applyStimulus(2, 3'b000, 8'hAA, 8'h55);
    waitDrained(30);
    checkOutput("nop_no_start", start_count - s0, 0);
    for (int k = 5; k <= 7; k++) begin
      applyStimulus(1, 3'(k), 8'h33, 8'h44);
      waitDrained(30);
    end
    checkOutput("illegal_no_start", start_count - s0, 0);

    $display("[TB] back-to-back issue");
    base = grant_log.size();
    applyStimulus(0, 3'b001, 8'h10, 8'h20);
    tick();
    applyStimulus(0, 3'b010, 8'hF0, 8'h3C);
    waitDrained(40);
    checkOutput("b2b_gap", acceptAt(base + 1) - acceptAt(base), LAT_SINGLE + 1);

    $display("[TB] reset during MUL");
    applyStimulus(2, 3'b100, 8'h80, 8'h03);
    repeat (3) tick();
    checkOutput("pre_rst_busy", 32'(alu_start), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_alu_start", 32'(alu_start), 32'd0);
    checkOutput("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("mid_rst_alu_ops", {8'd0, alu_A, alu_B, 5'd0, alu_op}, 32'd0);
    checkOutput("mid_rst_rsp_data", {15'd0, rsp_err, rsp_result}, 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (8) tick();
    base = grant_log.size();
    applyStimulus(1, 3'b001, 8'h7F, 8'h01);
    applyStimulus(3, 3'b001, 8'h01, 8'h02);
    waitDrained(40);
    checkOutput("post_rst_grant", grantAt(base), 1);
    checkOutput("post_rst_grant2", grantAt(base + 1), 3);

    $display("[TB] random traffic");
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 2; j++) begin
        rop = 3'($urandom_range(0, 7));
        applyStimulus(int'($urandom_range(0, NUM_REQ - 1)), rop,
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end
      waitDrained(80);
    end

`ifdef TINYALU_ARB_TIMEOUT_EN
    $display("[TB] BUSY timeout");
    alu_stall = 1'b1;
    applyStimulus(0, 3'b001, 8'h01, 8'h02);
    waitDrained(80);
    alu_stall = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tinyalu_arbiter.md
Name: tinyalu_arbiter

Overview:
Round-robin controller that shares one tinyalu between NUM_REQ requesters. It accepts a request, latches its operands and op, and sequences the ALU start/done handshake. The result goes back to the owning requester as a one-cycle response pulse. It sits between the requester ports and the ALU's A/B/op/start/done/result pins, and is the only driver of those ALU inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MUL_DRAIN, 2, idle cycles with alu_start low after a multiply completes, before the next issue
TIMEOUT_CYCLES, 15, maximum BUSY cycles before abort (used only with the optional feature)

Ports:
clk  in  1  clock, all logic on the rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester request
req_ready  out  NUM_REQ  one-hot accept, combinational, high only in IDLE for the granted index
req_A  in  8*NUM_REQ  operand A, slice i belongs to requester i
req_B  in  8*NUM_REQ  operand B
req_op  in  3*NUM_REQ  opcode
rsp_valid  out  NUM_REQ  one-hot response pulse, one cycle long
rsp_result  out  16  result, valid while any rsp_valid bit is high
rsp_err  out  1  error flag, valid with rsp_valid
alu_A  out  8  ALU operand A
alu_B  out  8  ALU operand B
alu_op  out  3  ALU opcode
alu_start  out  1  ALU start
alu_done  in  1  ALU done
alu_result  in  16  ALU result

Behaviour:
- Reset (async, reset_n=0): state=IDLE, rr pointer=0, all outputs 0, latched operands 0. Reset mid-operation aborts the operation; no response is issued.
- Opcodes: 000 NOP, 001 ADD, 010 AND, 011 XOR, 100 MUL; 101..111 are illegal.
- IDLE:
  - Grant goes to the lowest index >= pointer with req_valid=1, wrapping. req_ready[grant]=1 in the same cycle.
  - A/B/op are latched and the pointer advances to grant+1 (mod NUM_REQ).
  - Next state: NOP -> RESP; illegal -> RESP with err; otherwise -> BUSY.
- BUSY:
  - alu_start=1; alu_A/B/op held stable from the latch.
  - When alu_done=1: capture alu_result, go to RESP.
- RESP (1 cycle):
  - alu_start=0; rsp_valid[owner]=1.
  - rsp_result = captured value; 0 for NOP or illegal.
  - rsp_err=1 only for illegal ops (or timeout).
  - Next state: DRAIN if op was MUL, else IDLE.
- DRAIN: alu_start=0; a down-counter loaded with MUL_DRAIN; return to IDLE when it reaches 0. alu_done is ignored in DRAIN and IDLE.
- Latency, from the accept cycle c to the rsp_valid cycle:
  - ADD/AND/XOR: c+3
  - MUL: c+6
  - NOP and illegal: c+1
- Back-to-back: a non-MUL op can be accepted again in cycle c+4.
- req_valid dropping after accept has no effect. Changes to a requester's operands after accept are ignored.
- alu_A/B/op retain their last value outside BUSY.

Optional Feature:
TINYALU_ARB_TIMEOUT_EN
- Defined: a BUSY cycle counter runs. If alu_done stays 0 for TIMEOUT_CYCLES cycles, alu_start drops and the block goes to RESP with rsp_err=1 and rsp_result=0, then to DRAIN loaded with MUL_DRAIN.
- Undefined: no counter; BUSY waits for alu_done indefinitely.

Decomposition:
- tinyalu_pkg holds:
  - op enum: NOP, ADD, AND, XOR, MUL
  - state enum: IDLE, BUSY, RESP, DRAIN
  - latency constants: 3 for single-cycle ops, 6 for MUL
- One sub-module, tinyalu_rr_arbiter: parameterised round-robin grant logic with req vector and pointer in, one-hot grant out.

Test Plan:
- ADD: req0 ADD A=8'hFF B=8'h01 accepted in cycle c -> rsp_valid[0] in c+3, rsp_result=16'h0100, rsp_err=0.
- MUL: req1 MUL A=8'hFF B=8'hFF -> rsp_valid[1] in c+6, rsp_result=16'hFE01. The next accept is no earlier than c+7+MUL_DRAIN.
- Round-robin: req0/1/2 all valid with pointer=0 -> grants 0,1,2 in order. Then req0 and req3 valid -> grant 3 before 0.
- NOP and illegal: NOP -> rsp in c+1 with result 0, err 0, and alu_start never asserted. Op 3'b110 -> rsp in c+1 with err=1.
- Reset: reset_n pulsed low during BUSY of a MUL -> all outputs 0 immediately, no rsp_valid. A fresh ADD afterwards completes normally.
- Timeout (TINYALU_ARB_TIMEOUT_EN defined, alu_done tied 0): ADD -> rsp_err=1 and rsp_result=0 after 15 BUSY cycles.
